sel_arbiter: RTL and testbench
==============================

SEL_ARBITER -- requirements
Module: sel_arbiter

Interface
REQ-001 Parameter: WIDTH, 8, data width of each requester and of the output.
REQ-002 Parameter: MAX_BEATS, 16, maximum accepted beats per grant before forced release (>=1).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
REQ-004 CLK  input  1  rising-edge clock.
REQ-005 RST_N  input  1  asynchronous active-low reset.
REQ-006 A_VALID  input  1  requester A has a beat.
REQ-007 A_DATA  input  WIDTH  requester A data.
REQ-008 A_LAST  input  1  final beat of A's burst.
REQ-009 A_READY  output  1  A's beat is accepted this cycle.
REQ-010 B_VALID, B_DATA, B_LAST, B_READY  same as A, for requester B.
REQ-011 OUT_VALID  output  1  output beat valid.
REQ-012 OUT_DATA  output  WIDTH  selected data.
REQ-013 OUT_LAST  output  1  selected LAST.
REQ-014 OUT_READY  input  1  downstream accepts.
REQ-015 SEL  output  1  registered mux select; 0 = A, 1 = B.
REQ-016 GNT_A, GNT_B  output  1 each  current owner, one-hot or both 0.
REQ-017 OVF  output  1  one-cycle pulse on forced release.

Function
REQ-018 FSM states SHALL be IDLE, OWN_A and OWN_B; GNT_A = (state==OWN_A) and GNT_B = (state==OWN_B).
REQ-019 The datapath SHALL be a 2:1 selector: OUT_DATA/OUT_LAST = SEL ? B : A, combinational from the SEL register.
REQ-020 In IDLE: OUT_VALID=0, A_READY=B_READY=0, SEL holds its last value.
REQ-021 IDLE, only A_VALID -> OWN_A, SEL<=0; only B_VALID -> OWN_B, SEL<=1; neither -> stay.
REQ-022 IDLE, both valid -> grant the requester not served last (LAST_OWN register); ties therefore alternate.
REQ-023 Arbitration latency SHALL be one cycle: valid seen in IDLE at edge N, first beat transferable in cycle N+1.
REQ-024 In OWN_x: OUT_VALID = x_VALID, x_READY = OUT_READY, other requester's READY = 0.
REQ-025 A beat is accepted when x_VALID & OUT_READY in OWN_x; the beat counter increments per accepted beat, cleared on every new grant.
REQ-026 Release SHALL occur on an accepted beat with x_LAST=1, or on the accepted beat that makes the count equal MAX_BEATS.
REQ-027 Forced release (count reaches MAX_BEATS with x_LAST=0) SHALL pulse OVF high for exactly the following cycle; the LAST-terminated case, including LAST on beat MAX_BEATS, SHALL not pulse OVF.
REQ-028 On release, if the other requester's VALID is high, go directly to OWN_other with SEL toggled (no bubble); otherwise go to IDLE.
REQ-029 LAST_OWN SHALL update to x on every release from OWN_x.
REQ-030 x_VALID dropping mid-burst SHALL NOT release the grant; OUT_VALID follows at 0 until x_VALID returns.
REQ-031 OUT_READY low SHALL stall: no counter change, no state change.
REQ-032 Beat counter width SHALL be ceil(log2(MAX_BEATS+1)); no wrap is reachable.

Reset
REQ-033 On RST_N=0 (asynchronous): state=IDLE, SEL=0, LAST_OWN=B (A wins first tie), count=0, OVF=0, GNT_A=GNT_B=0.
REQ-034 Reset mid-burst SHALL deassert A_READY, B_READY and OUT_VALID immediately (same cycle) and discard the burst.
REQ-035 After RST_N rises, the first arbitration SHALL occur at the first CLK edge with RST_N high.

Verification
REQ-036 Reset then A_VALID=1, B_VALID=1, OUT_READY=1, 3-beat bursts each -> A owns 3 beats, B owns next 3 with no idle cycle, SEL 0->1.
REQ-037 Both valid continuously, 1-beat bursts -> grants alternate A,B,A,B each cycle after first; OVF never set.
REQ-038 MAX_BEATS=4, A streams with A_LAST=0 -> 4 beats accepted, OVF=1 one cycle, IDLE (B idle), then A re-granted next cycle.
REQ-039 OWN_A, OUT_READY toggled 0/1 and A_VALID gaps -> no beat lost or duplicated, A_READY=0 whenever OUT_READY=0, grant held.
REQ-040 RST_N pulled low during beat 2 of a 5-beat B burst -> GNT_B, B_READY, OUT_VALID drop same cycle; after release, tie resolves to A.

Source files
------------

// File: rtl/sel_arbiter_if.sv
// rtl/sel_arbiter_if.sv - requester, output stream and status signals of the two-way burst arbiter
interface sel_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_last;
  logic             a_ready;

  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_last;
  logic             b_ready;

  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_ready;

  logic             sel;
  logic             gnt_a;
  logic             gnt_b;
  logic             ovf;

  // Environment side: drives both requesters and the downstream ready.
  modport master (
    output a_valid, a_data, a_last,
    input  a_ready,
    output b_valid, b_data, b_last,
    input  b_ready,
    input  out_valid, out_data, out_last,
    output out_ready,
    input  sel, gnt_a, gnt_b, ovf
  );

  // Arbiter side.
  modport slave (
    input  a_valid, a_data, a_last,
    output a_ready,
    input  b_valid, b_data, b_last,
    output b_ready,
    output out_valid, out_data, out_last,
    input  out_ready,
    output sel, gnt_a, gnt_b, ovf
  );
endinterface

// File: rtl/sel_arbiter.sv
// rtl/sel_arbiter.sv - two-requester burst arbiter with a registered 2:1 output select
// Bursts end on LAST or after MAX_BEATS accepted beats; ties go to the requester not served last.
module sel_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input logic          clk,
  input logic          rst_n,
  sel_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  localparam int             CW      = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_BEATS);

  state_t        state;
  logic          sel_q;
  logic          last_own_b;
  logic [CW-1:0] count;
  logic          ovf_q;

  logic          own_a;
  logic          own_b;
  logic          beat_a;
  logic          beat_b;
  logic [CW-1:0] count_inc;
  logic          at_max;

  assign own_a     = (state == OWN_A);
  assign own_b     = (state == OWN_B);
  assign beat_a    = own_a & bus.a_valid & bus.out_ready;
  assign beat_b    = own_b & bus.b_valid & bus.out_ready;
  assign count_inc = count + 1'b1;
  assign at_max    = (count_inc == MAX_CNT);

  // Handshake outputs decode straight from state so an asynchronous reset drops them at once.
  assign bus.a_ready   = own_a & bus.out_ready;
  assign bus.b_ready   = own_b & bus.out_ready;
  assign bus.out_valid = (own_a & bus.a_valid) | (own_b & bus.b_valid);
  assign bus.out_data  = sel_q ? bus.b_data : bus.a_data;
  assign bus.out_last  = sel_q ? bus.b_last : bus.a_last;
  assign bus.sel       = sel_q;
  assign bus.gnt_a     = own_a;
  assign bus.gnt_b     = own_b;
  assign bus.ovf       = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel_q      <= 1'b0;
      last_own_b <= 1'b1;
      count      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      case (state)
        IDLE: begin
          count <= '0;
          if (bus.a_valid && (!bus.b_valid || last_own_b)) begin
            state <= OWN_A;
            sel_q <= 1'b0;
          end else if (bus.b_valid) begin
            state <= OWN_B;
            sel_q <= 1'b1;
          end
        end

        OWN_A: begin
          if (beat_a) begin
            if (bus.a_last || at_max) begin
              last_own_b <= 1'b0;
              ovf_q      <= ~bus.a_last;
              count      <= '0;
              if (bus.b_valid) begin
                state <= OWN_B;
                sel_q <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end else begin
              count <= count_inc;
            end
          end
        end

        OWN_B: begin
          if (beat_b) begin
            if (bus.b_last || at_max) begin
              last_own_b <= 1'b1;
              ovf_q      <= ~bus.b_last;
              count      <= '0;
              if (bus.a_valid) begin
                state <= OWN_A;
                sel_q <= 1'b0;
              end else begin
                state <= IDLE;
              end
            end else begin
              count <= count_inc;
            end
          end
        end

        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sel_arbiter.sv
// tb/tb_sel_arbiter.sv - directed self-checking bench for sel_arbiter with MAX_BEATS=4
module tb_sel_arbiter;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  sel_arbiter_if #(.WIDTH(8)) bus ();

  sel_arbiter #(
    .WIDTH    (8),
    .MAX_BEATS(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // {gnt_a, gnt_b, sel, ovf, out_valid, a_ready, b_ready}
  logic [6:0] flags;
  assign flags = {bus.gnt_a, bus.gnt_b, bus.sel, bus.ovf, bus.out_valid, bus.a_ready, bus.b_ready};

  localparam logic [6:0] F_IDLE_S0 = 7'b0000000;
  localparam logic [6:0] F_IDLE_S1 = 7'b0010000;
  localparam logic [6:0] F_OWN_A   = 7'b1000110;
  localparam logic [6:0] F_OWN_B   = 7'b0110101;
  localparam logic [6:0] F_OVF     = 7'b0001000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n         = 1'b0;
    bus.a_valid   = 1'b0;
    bus.a_data    = 8'h3C;
    bus.a_last    = 1'b0;
    bus.b_valid   = 1'b0;
    bus.b_data    = 8'hC3;
    bus.b_last    = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    vectors++;
    if (flags !== F_IDLE_S0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected %b", flags, F_IDLE_S0);
    end
    vectors++;
    if (bus.out_data !== 8'h3C) begin
      miscompares++;
      $display("FAIL reset_out_data: got %h expected %h", bus.out_data, 8'h3C);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_d;
    bus.a_valid   = 1'b1;
    bus.b_valid   = 1'b1;
    bus.out_ready = 1'b1;
    bus.a_data    = 8'hA0;
    bus.b_data    = 8'hB0;
    #1;
    vectors++;
    if (flags !== F_IDLE_S0) begin
      miscompares++;
      $display("FAIL b2b_idle_before: got %b expected %b", flags, F_IDLE_S0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_d      = 8'hA0 + 8'(i);
      bus.a_data = exp_d;
      bus.a_last = (i == 2);
      #1;
      vectors++;
      if (flags !== F_OWN_A || bus.out_data !== exp_d || bus.out_last !== (i == 2)) begin
        miscompares++;
        $display("FAIL b2b_a_beat%0d: got flags %b data %h last %b expected %b %h %b",
                 i, flags, bus.out_data, bus.out_last, F_OWN_A, exp_d, (i == 2));
      end
    end
    for (int j = 0; j < 3; j++) begin
      tick();
      bus.a_last = 1'b0;
      exp_d      = 8'hB0 + 8'(j);
      bus.b_data = exp_d;
      bus.b_last = (j == 2);
      if (j == 2) bus.a_valid = 1'b0;
      #1;
      vectors++;
      if (flags !== F_OWN_B || bus.out_data !== exp_d) begin
        miscompares++;
        $display("FAIL b2b_b_beat%0d: got flags %b data %h expected %b %h",
                 j, flags, bus.out_data, F_OWN_B, exp_d);
      end
    end
    tick();
    bus.b_valid = 1'b0;
    bus.b_last  = 1'b0;
    #1;
    vectors++;
    if (flags !== F_IDLE_S1) begin
      miscompares++;
      $display("FAIL b2b_idle_after: got %b expected %b", flags, F_IDLE_S1);
    end
  endtask

  task automatic test_alternate;
    logic [6:0] exp_f;
    logic [7:0] exp_d;
    bus.a_valid   = 1'b1;
    bus.b_valid   = 1'b1;
    bus.a_last    = 1'b1;
    bus.b_last    = 1'b1;
    bus.a_data    = 8'h11;
    bus.b_data    = 8'h22;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 5) bus.a_valid = 1'b0;
      #1;
      exp_f = (i % 2 == 0) ? F_OWN_A : F_OWN_B;
      exp_d = (i % 2 == 0) ? 8'h11 : 8'h22;
      vectors++;
      if (flags !== exp_f || bus.out_data !== exp_d) begin
        miscompares++;
        $display("FAIL alt_cycle%0d: got flags %b data %h expected %b %h",
                 i, flags, bus.out_data, exp_f, exp_d);
      end
    end
    tick();
    bus.b_valid = 1'b0;
    bus.a_last  = 1'b0;
    bus.b_last  = 1'b0;
    #1;
    vectors++;
    if (flags !== F_IDLE_S1) begin
      miscompares++;
      $display("FAIL alt_idle_after: got %b expected %b", flags, F_IDLE_S1);
    end
  endtask

  task automatic test_overflow;
    logic [7:0] exp_d;
    bus.a_valid   = 1'b1;
    bus.a_last    = 1'b0;
    bus.b_valid   = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      exp_d      = 8'h70 + 8'(i);
      bus.a_data = exp_d;
      #1;
      vectors++;
      if (flags !== F_OWN_A || bus.out_data !== exp_d) begin
        miscompares++;
        $display("FAIL ovf_beat%0d: got flags %b data %h expected %b %h",
                 i, flags, bus.out_data, F_OWN_A, exp_d);
      end
      tick();
    end
    vectors++;
    if (flags !== F_OVF) begin
      miscompares++;
      $display("FAIL ovf_pulse: got %b expected %b", flags, F_OVF);
    end
    tick();
    vectors++;
    if (flags !== F_OWN_A) begin
      miscompares++;
      $display("FAIL ovf_regrant: got %b expected %b", flags, F_OWN_A);
    end
    for (int i = 0; i < 4; i++) begin
      bus.a_last = (i == 3);
      #1;
      vectors++;
      if (flags !== F_OWN_A) begin
        miscompares++;
        $display("FAIL last_at_max_beat%0d: got %b expected %b", i, flags, F_OWN_A);
      end
      tick();
    end
    vectors++;
    if (flags !== F_IDLE_S0) begin
      miscompares++;
      $display("FAIL last_at_max_no_ovf: got %b expected %b", flags, F_IDLE_S0);
    end
    bus.a_valid = 1'b0;
    bus.a_last  = 1'b0;
    tick();
  endtask

  task automatic test_stall;
    logic [6:0] v_pat;
    logic [6:0] r_pat;
    logic [7:0] exp_d;
    int         idx;
    v_pat = 7'b1011011;  // bit k = a_valid in cycle k
    r_pat = 7'b1110110;  // bit k = out_ready in cycle k
    idx   = 0;
    bus.a_valid   = 1'b1;
    bus.out_ready = 1'b0;
    bus.a_data    = 8'h50;
    bus.a_last    = 1'b0;
    bus.b_valid   = 1'b0;
    tick();
    for (int k = 0; k < 7; k++) begin
      bus.a_valid   = v_pat[k];
      bus.out_ready = r_pat[k];
      exp_d         = 8'h50 + 8'(idx);
      bus.a_data    = exp_d;
      bus.a_last    = (idx == 2);
      #1;
      vectors++;
      if ({bus.gnt_a, bus.gnt_b, bus.out_valid, bus.a_ready, bus.b_ready} !==
          {1'b1, 1'b0, v_pat[k], r_pat[k], 1'b0}) begin
        miscompares++;
        $display("FAIL stall_cycle%0d: got %b expected %b", k,
                 {bus.gnt_a, bus.gnt_b, bus.out_valid, bus.a_ready, bus.b_ready},
                 {1'b1, 1'b0, v_pat[k], r_pat[k], 1'b0});
      end
      if (v_pat[k] && r_pat[k]) begin
        vectors++;
        if (bus.out_data !== exp_d) begin
          miscompares++;
          $display("FAIL stall_data%0d: got %h expected %h", idx, bus.out_data, exp_d);
        end
        idx++;
      end
      tick();
    end
    vectors++;
    if (flags !== F_IDLE_S0) begin
      miscompares++;
      $display("FAIL stall_release: got %b expected %b", flags, F_IDLE_S0);
    end
    bus.a_valid = 1'b0;
    bus.a_last  = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_burst;
    bus.a_valid   = 1'b0;
    bus.b_valid   = 1'b1;
    bus.b_last    = 1'b0;
    bus.b_data    = 8'h90;
    bus.out_ready = 1'b1;
    tick();
    vectors++;
    if (flags !== F_OWN_B) begin
      miscompares++;
      $display("FAIL rst_mid_beat1: got %b expected %b", flags, F_OWN_B);
    end
    tick();
    bus.b_data = 8'h91;
    #1;
    vectors++;
    if (flags !== F_OWN_B) begin
      miscompares++;
      $display("FAIL rst_mid_beat2: got %b expected %b", flags, F_OWN_B);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (flags !== F_IDLE_S0) begin
      miscompares++;
      $display("FAIL rst_mid_async_drop: got %b expected %b", flags, F_IDLE_S0);
    end
    bus.a_valid = 1'b1;
    tick();
    vectors++;
    if (flags !== F_IDLE_S0) begin
      miscompares++;
      $display("FAIL rst_mid_held: got %b expected %b", flags, F_IDLE_S0);
    end
    #1;
    rst_n = 1'b1;
    tick();
    vectors++;
    if (flags !== F_OWN_A) begin
      miscompares++;
      $display("FAIL rst_mid_tie_to_a: got %b expected %b", flags, F_OWN_A);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_back_to_back();
    test_alternate();
    test_overflow();
    test_stall();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
